isr_tracker: RTL
================

Name: isr_tracker

Overview:
- Bus-side responder to the trap/NMI controller. Watches Z80 opcode fetches and memory reads and reports two things back to the controller.
- `new_isr`: the next M1 starts a fresh instruction, not a prefix continuation, so a trap may be taken there.
- `last_isr_jmp`: the trap handler has just completed an unconditional `JP nn`, so the trap can end on the next M1.
- Sits between the Z80 bus pins and the trap controller. Clocked by the CPU clock.

Parameters:
- JP_OPCODE, 8'hC3, opcode byte that ends a trap.
- PFX_IX, 8'hDD, index prefix.
- PFX_IY, 8'hFD, index prefix.

Ports:
- clk  input  1  Z80 CPU clock; all state changes on its rising edge.
- rst  input  1  asynchronous active-high reset.
- m1_n  input  1  Z80 M1.
- mreq_n  input  1  Z80 MREQ.
- rd_n  input  1  Z80 RD.
- iorq_n  input  1  Z80 IORQ; an INTA cycle (m1_n and iorq_n low) is never treated as a fetch.
- data_in  input  8  Z80 data bus.
- trap_state  input  1  high while the trap controller is in trap mode.
- new_isr  output  1  high = instruction boundary.
- last_isr_jmp  output  1  high = trap-ending JP just completed.
- jmp_target  output  16  operand of the last tracked JP, {hi,lo}.

Behaviour:
- Reset (async, rst=1): state=BOUNDARY, new_isr=1, last_isr_jmp=0, jmp_target=16'h0000, internal byte latch cleared, rd_q=1.
- Cycle classification, per posedge:
  - Opcode fetch active: m1_n=0, mreq_n=0, rd_n=0, iorq_n=1.
  - Memory read active: m1_n=1, mreq_n=0, rd_n=0.
  - Refresh, I/O and INTA cycles are ignored.
- Byte capture:
  - While a fetch or read is active, data_in is latched every posedge, along with its cycle type.
  - Completion = first posedge where rd_n=1 and rd_q=0 (rd_q is rd_n registered).
  - The latched byte and type are processed on that edge.
  - The latched byte is therefore the last value present while RD was low.
- States: BOUNDARY, PREFIX, EDCB, XCB1, XCB2, JP_LO, JP_HI, ARMED.
- Opcode fetch completing in BOUNDARY or ARMED:
  - DD or FD -> PREFIX.
  - ED or CB -> EDCB.
  - JP_OPCODE with trap_state=1 -> JP_LO.
  - Otherwise -> BOUNDARY.
  - In ARMED, last_isr_jmp clears on this edge whatever the byte.
- Opcode fetch completing in PREFIX:
  - DD or FD -> PREFIX (prefix chain).
  - CB -> XCB1.
  - ED -> EDCB.
  - JP_OPCODE with trap_state=1 -> JP_LO.
  - Otherwise -> BOUNDARY.
- Opcode fetch completing in EDCB -> BOUNDARY. The second byte is always the final opcode.
- XCB1: memory read completion -> XCB2. XCB2: memory read completion -> BOUNDARY. (DDCB d op: displacement and opcode are non-M1 reads.)
- JP_LO: memory read completion -> jmp_target[7:0]=byte, go to JP_HI.
- JP_HI: memory read completion -> jmp_target[15:8]=byte, go to ARMED.
- Abort rule: an opcode fetch completing in JP_LO, JP_HI, XCB1 or XCB2 is decoded as if the state were BOUNDARY. The partial jmp_target bytes are kept.
- Outputs are registered from state:
  - new_isr = 1 in BOUNDARY and ARMED, 0 otherwise.
  - last_isr_jmp = 1 only in ARMED.
  - Both are stable before the falling edge of m1_n of the following fetch, because M1 falls at least one clk after RD rises.
- trap_state falling while in JP_LO, JP_HI or ARMED:
  - Go to BOUNDARY on the next posedge; last_isr_jmp=0.
  - Prefix and CB states are unaffected.
- trap_state=0 never causes entry to JP_LO. C3 is then a plain instruction (-> BOUNDARY).
- Memory read completing in BOUNDARY, PREFIX, EDCB or ARMED: no state change (operand of an untracked instruction).
- Simultaneous completion and trap_state fall on the same edge: the trap_state rule wins (BOUNDARY).
- Reset asserted mid-instruction forces BOUNDARY immediately. Tracking resumes at the next completed fetch.

Test Plan:
- Reset, then release with bus idle -> new_isr=1, last_isr_jmp=0, jmp_target=0000.
- trap_state=1; fetch C3, reads 34, 12 -> new_isr=0 after C3; after 12: state ARMED, jmp_target=1234, last_isr_jmp=1, new_isr=1. Next fetch 00 completes -> last_isr_jmp=0.
- trap_state=0; fetch C3, reads 34, 12 -> last_isr_jmp stays 0; new_isr=1 throughout; jmp_target unchanged.
- Fetch DD, then CB, reads 05, 46 -> new_isr=0 from DD completion until the 46 read completes, then 1.
- trap_state=1; fetch FD, FD, C3 -> new_isr=0, JP_LO entered. Drop trap_state before reads -> BOUNDARY, last_isr_jmp never asserts.
- trap_state=1; fetch C3, read 00, then assert rst -> new_isr=1 and last_isr_jmp=0 immediately (asynchronous, no clock edge needed).

Source files
------------

// File: rtl/isr_tracker.sv
// rtl/isr_tracker.sv - Z80 instruction-boundary and trap-ending JP tracker for the trap/NMI controller.
module isr_tracker #(
    parameter logic [7:0] JP_OPCODE = 8'hC3,
    parameter logic [7:0] PFX_IX    = 8'hDD,
    parameter logic [7:0] PFX_IY    = 8'hFD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        iorq_n,
    input  logic [7:0]  data_in,
    input  logic        trap_state,
    output logic        new_isr,
    output logic        last_isr_jmp,
    output logic [15:0] jmp_target
);

    localparam logic [7:0] PFX_ED = 8'hED;
    localparam logic [7:0] PFX_CB = 8'hCB;

    typedef enum logic [2:0] {
        ST_BOUNDARY,
        ST_PREFIX,
        ST_EDCB,
        ST_XCB1,
        ST_XCB2,
        ST_JP_LO,
        ST_JP_HI,
        ST_ARMED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rd_q;
    logic [7:0]  cap_byte;
    logic        cap_fetch;
    logic        cap_valid;
    logic        fetch_active;
    logic        read_active;
    logic        complete;
    logic        tgt_lo_we;
    logic        tgt_hi_we;
    logic        in_jp_track;

    // INTA has iorq_n low and must never look like a fetch.
    assign fetch_active = ~m1_n & ~mreq_n & ~rd_n & iorq_n;
    assign read_active  = m1_n & ~mreq_n & ~rd_n;
    assign complete     = rd_n & ~rd_q & cap_valid;
    assign in_jp_track  = (state == ST_JP_LO) || (state == ST_JP_HI) || (state == ST_ARMED);

    function automatic state_t decode_fetch(input logic [7:0] op, input logic after_prefix,
                                            input logic trap);
        state_t ns;
        ns = ST_BOUNDARY;
        if (op == PFX_IX || op == PFX_IY)
            ns = ST_PREFIX;
        else if (op == PFX_ED)
            ns = ST_EDCB;
        else if (op == PFX_CB)
            ns = after_prefix ? ST_XCB1 : ST_EDCB;
        else if (op == JP_OPCODE && trap)
            ns = ST_JP_LO;
        return ns;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q      <= 1'b1;
            cap_byte  <= 8'h00;
            cap_fetch <= 1'b0;
            cap_valid <= 1'b0;
        end else begin
            rd_q <= rd_n;
            if (fetch_active || read_active) begin
                cap_byte  <= data_in;
                cap_fetch <= fetch_active;
                cap_valid <= 1'b1;
            end else if (complete) begin
                cap_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        tgt_lo_we  = 1'b0;
        tgt_hi_we  = 1'b0;
        // Leaving trap mode drops any JP tracking, even on a completion edge.
        if (!trap_state && in_jp_track) begin
            state_next = ST_BOUNDARY;
        end else if (complete) begin
            if (cap_fetch) begin
                case (state)
                    ST_PREFIX: state_next = decode_fetch(cap_byte, 1'b1, trap_state);
                    ST_EDCB:   state_next = ST_BOUNDARY;
                    default:   state_next = decode_fetch(cap_byte, 1'b0, trap_state);
                endcase
            end else begin
                case (state)
                    ST_XCB1: state_next = ST_XCB2;
                    ST_XCB2: state_next = ST_BOUNDARY;
                    ST_JP_LO: begin
                        tgt_lo_we  = 1'b1;
                        state_next = ST_JP_HI;
                    end
                    ST_JP_HI: begin
                        tgt_hi_we  = 1'b1;
                        state_next = ST_ARMED;
                    end
                    default: state_next = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_BOUNDARY;
            new_isr      <= 1'b1;
            last_isr_jmp <= 1'b0;
            jmp_target   <= 16'h0000;
        end else begin
            state        <= state_next;
            new_isr      <= (state_next == ST_BOUNDARY) || (state_next == ST_ARMED);
            last_isr_jmp <= (state_next == ST_ARMED);
            if (tgt_lo_we)
                jmp_target[7:0] <= cap_byte;
            if (tgt_hi_we)
                jmp_target[15:8] <= cap_byte;
        end
    end

endmodule
